// File: rtl/dtfag_rom_seq.sv
// rtl/dtfag_rom_seq.sv - twiddle-factor ROM address sequencer: 4 stages x 4096 groups, 1-cycle ROM latency.
// Optional unit-twiddle ROM access skipping under macro DTFAG_ZERO_SKIP_EN.
module dtfag_rom_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              ROM_CEN,
  output logic [ADDR_W-1:0] MA0,
  output logic [ADDR_W-1:0] MA1,
  output logic [ADDR_W-1:0] MA2,
  output logic              tf_valid,
  output logic              tf_one,
  output logic [1:0]        tf_stage,
  output logic              tf_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        s;
  logic [11:0]       j;
  logic [11:0]       e;
  logic              issue;
  logic              final_issue;
  logic              abort_eff;
  logic [ADDR_W-1:0] ma0_q, ma1_q, ma2_q;
  logic              tf_valid_q, tf_last_q;
  logic [1:0]        tf_stage_q;

  // Group index scaled by 16^s, truncated to the 12-bit ROM index space.
  assign e           = j << {s, 2'b00};
  assign final_issue = issue && (s == 2'd3) && (j == 12'hfff);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    abort_eff = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        issue     = !hold;
        abort_eff = abort;
        if (abort)            state_nxt = IDLE;
        else if (final_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        abort_eff = abort;
        state_nxt = abort ? IDLE : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= 2'd0;
      j          <= 12'd0;
      ma0_q      <= '0;
      ma1_q      <= '0;
      ma2_q      <= '0;
      tf_valid_q <= 1'b0;
      tf_last_q  <= 1'b0;
      tf_stage_q <= 2'd0;
    end else begin
      if (state != RUN) begin
        s <= 2'd0;
        j <= 12'd0;
      end else if (issue) begin
        j <= j + 12'd1;
        if (j == 12'hfff) s <= s + 2'd1;
      end
      if (issue) begin
        ma0_q <= ADDR_W'(e[3:0]);
        ma1_q <= ADDR_W'(e[7:4]);
        ma2_q <= ADDR_W'(e[11:8]);
      end
      tf_valid_q <= issue && !abort_eff;
      tf_last_q  <= final_issue && !abort_eff;
      tf_stage_q <= s;
    end
  end

`ifdef DTFAG_ZERO_SKIP_EN
  logic tf_one_q;

  // A zero index is the unit twiddle: the ROM is left idle and tf_one stands in for its data.
  always_ff @(posedge clk) begin
    if (rst) tf_one_q <= 1'b0;
    else     tf_one_q <= issue && (e == 12'd0) && !abort_eff;
  end

  assign ROM_CEN = !(issue && (e != 12'd0));
  assign tf_one  = tf_one_q;
`else
  assign ROM_CEN = !issue;
  assign tf_one  = 1'b0;
`endif

  assign MA0      = issue ? ADDR_W'(e[3:0])  : ma0_q;
  assign MA1      = issue ? ADDR_W'(e[7:4])  : ma1_q;
  assign MA2      = issue ? ADDR_W'(e[11:8]) : ma2_q;
  assign tf_valid = tf_valid_q;
  assign tf_last  = tf_last_q;
  assign tf_stage = tf_stage_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_dtfag_rom_seq.sv
// tb/tb_dtfag_rom_seq.sv - self-checking bench for dtfag_rom_seq against an issue-count reference model.
module tb_dtfag_rom_seq;

`ifdef DTFAG_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic       clk;
  logic       rst, start, abort, hold;
  logic       ROM_CEN;
  logic [3:0] MA0, MA1, MA2;
  logic       tf_valid, tf_one, tf_last, busy, done;
  logic [1:0] tf_stage;

  dtfag_rom_seq #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .ROM_CEN(ROM_CEN), .MA0(MA0), .MA1(MA1), .MA2(MA2),
    .tf_valid(tf_valid), .tf_one(tf_one), .tf_stage(tf_stage),
    .tf_last(tf_last), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         idx;
    logic [3:0] m0, m1, m2;
  } vec_t;
  vec_t vecs[8];

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; n = issues completed in this sweep.
  int         cyc = 0;
  int         m_phase = 0;
  int         m_n = 0;
  bit         m_known = 0;
  bit         m_valid = 0, m_one = 0, m_last = 0;
  int         m_stage = 0;
  logic [3:0] m_ma0 = 0, m_ma1 = 0, m_ma2 = 0;

  int  cnt_valid, cnt_one, cnt_cen0, cnt_done;
  int  last_cyc, done_cyc, busy0_cyc;
  bit  prev_busy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    int s_, j_, e_;
    bit iss, ab, exp_cen;
    logic [3:0] f0, f1, f2, x0, x1, x2;
    #1;
    iss = (m_phase == 1) && !hold;
    s_  = m_n / 4096;
    j_  = m_n % 4096;
    e_  = (j_ * (1 << (4 * s_))) % 4096;
    f0 = 4'(e_ % 16);
    f1 = 4'((e_ / 16) % 16);
    f2 = 4'(e_ / 256);
    x0 = iss ? f0 : m_ma0;
    x1 = iss ? f1 : m_ma1;
    x2 = iss ? f2 : m_ma2;
    exp_cen = iss ? (ZS && e_ == 0) : 1'b1;
    if (m_known) begin
      chk("ctrl", {busy, done, ROM_CEN, tf_valid, tf_one, tf_last},
          {m_phase != 0, m_phase == 3, exp_cen, m_valid, m_one, m_last});
      chk("addr", {MA0, MA1, MA2}, {x0, x1, x2});
      if (m_valid) chk("stage", tf_stage, m_stage[1:0]);
      if (iss)
        for (int v = 0; v < 8; v++)
          if (vecs[v].idx == m_n)
            chk($sformatf("vec%0d", v), {MA0, MA1, MA2}, {vecs[v].m0, vecs[v].m1, vecs[v].m2});
      if (tf_valid) cnt_valid++;
      if (tf_valid && tf_one) cnt_one++;
      if (!ROM_CEN) cnt_cen0++;
      if (done) begin cnt_done++; done_cyc = cyc; end
      if (tf_valid && tf_last) last_cyc = cyc;
      if (!busy && prev_busy) busy0_cyc = cyc;
      prev_busy = busy;
    end
    ab = abort && (m_phase == 1 || m_phase == 2);
    if (rst) begin
      m_known = 1; m_phase = 0; m_n = 0;
      m_valid = 0; m_one = 0; m_last = 0; m_stage = 0;
      m_ma0 = 0; m_ma1 = 0; m_ma2 = 0;
    end else begin
      if (iss) begin m_ma0 = f0; m_ma1 = f1; m_ma2 = f2; m_stage = s_; end
      m_valid = iss && !ab;
      m_one   = iss && !ab && ZS && (e_ == 0);
      m_last  = iss && !ab && (m_n == 16383);
      case (m_phase)
        0: if (start) begin m_phase = 1; m_n = 0; end
        1: if (ab) m_phase = 0;
           else if (iss) begin
             m_n++;
             if (m_n == 16384) m_phase = 2;
           end
        2: m_phase = ab ? 0 : 3;
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    #1;
    chk(nm, {busy, done, ROM_CEN, tf_valid, tf_one, tf_last, tf_stage, MA0, MA1, MA2},
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'h000});
  endtask

  task automatic run_sweep(input string nm, input int hold_at, input bit rnd);
    int t, holds, hleft;
    bit hold_done, ended;
    holds = 0; hleft = 0; hold_done = 0; ended = 0;
    cnt_valid = 0; cnt_one = 0; cnt_cen0 = 0; cnt_done = 0;
    last_cyc = -1; done_cyc = -1; busy0_cyc = -1;
    t = cyc;
    start = 1; cycle(); start = 0;
    for (int k = 0; k < 40000; k++) begin
      if (m_phase == 0) begin ended = 1; break; end
      hold = 0; abort = 0;
      start = rnd && (m_phase == 1 || m_phase == 2) && ($urandom_range(0, 15) == 0);
      if (m_phase == 1 && m_n == hold_at && !hold_done) begin hleft = 5; hold_done = 1; end
      if (hleft > 0) begin hold = 1; hleft--; end
      else if (rnd && $urandom_range(0, 7) == 0) hold = 1;
      if (rnd && m_phase == 3 && $urandom_range(0, 1) == 0) abort = 1;
      if (m_phase == 1 && hold) holds++;
      cycle();
    end
    hold = 0; abort = 0; start = 0;
    cycle();
    chk({nm, "_ended"}, ended, 1'b1);
    chk({nm, "_valid_n"}, cnt_valid, 16384);
    chk({nm, "_one_n"}, cnt_one, ZS ? 4369 : 0);
    chk({nm, "_cen0_n"}, cnt_cen0, ZS ? 12015 : 16384);
    chk({nm, "_done_n"}, cnt_done, 1);
    chk({nm, "_t_last"}, last_cyc - t, 16385 + holds);
    chk({nm, "_t_done"}, done_cyc - t, 16386 + holds);
    chk({nm, "_t_idle"}, busy0_cyc - t, 16387 + holds);
  endtask

  task automatic run_to(input string nm, input int n);
    bit found;
    found = 0;
    for (int k = 0; k < 20000; k++) begin
      if (m_phase == 1 && m_n == n) begin found = 1; break; end
      cycle();
    end
    chk({nm, "_reached"}, found, 1'b1);
  endtask

  initial begin
    vecs[0] = '{0,             4'h0, 4'h0, 4'h0};
    vecs[1] = '{'h0abc,        4'hc, 4'hb, 4'ha};
    vecs[2] = '{4096 + 'h123,  4'h0, 4'h3, 4'h2};
    vecs[3] = '{4096 + 'hfff,  4'h0, 4'hf, 4'hf};
    vecs[4] = '{8192 + 'h123,  4'h0, 4'h0, 4'h3};
    vecs[5] = '{8192 + 'h0f7,  4'h0, 4'h0, 4'h7};
    vecs[6] = '{12288 + 5,     4'h0, 4'h0, 4'h0};
    vecs[7] = '{16383,         4'h0, 4'h0, 4'h0};

    rst = 1; start = 1; abort = 1; hold = 1;
    @(negedge clk);
    repeat (3) cycle();
    rst = 0; start = 0; abort = 0; hold = 0;
    chk_reset("rst_init");
    repeat (2) cycle();

    run_sweep("sweep_plain", -1, 1'b0);
    run_sweep("sweep_hold", 10, 1'b1);

    start = 1; cycle(); start = 0;
    run_to("abort", 8192 + 100);
    abort = 1; hold = 1; cycle(); abort = 0; hold = 0;
    #1 chk("abort_busy", busy, 1'b0);
    cnt_done = 0;
    repeat (5) cycle();
    chk("abort_nodone", cnt_done, 0);
    start = 1; cycle(); start = 0;
    #1 chk("restart_ma", {MA0, MA1, MA2}, 12'h000);
    chk("restart_busy", busy, 1'b1);

    run_to("rstmid", 4096 + 7);
    rst = 1; start = 1; cycle(); rst = 0; start = 0;
    chk_reset("rst_mid");
    repeat (3) cycle();
    #1 chk("rst_idle", busy, 1'b0);
    start = 1; cycle(); start = 0;
    repeat (4) cycle();
    #1 chk("post_rst_ma0", {MA0, MA1, MA2}, 12'h400);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtfag_rom_seq.md
DTFAG_ROM_SEQ -- requirements
Module: dtfag_rom_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, the ROM address width driven on MA0/MA1/MA2; legal values are 4 or greater.
REQ-002 SHALL have the following ports (clock and reset first):
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a full 4-stage twiddle sweep.
- abort  input  1  cancels the sweep in progress.
- hold  input  1  downstream stall; freezes issue.
- ROM_CEN  output  1  active-low ROM chip enable, connected to the memory wrapper.
- MA0  output  ADDR_W  ROM0 address.
- MA1  output  ADDR_W  ROM1 address.
- MA2  output  ADDR_W  ROM2 address.
- tf_valid  output  1  ROM outputs carry the twiddle for the previously issued group.
- tf_one  output  1  twiddle equals 1, qualified by tf_valid.
- tf_stage  output  2  stage of the twiddle currently flagged valid.
- tf_last  output  1  final twiddle of the sweep, qualified by tf_valid.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at the end of a sweep.

Function
REQ-003 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-004 IDLE SHALL go to RUN on start=1; start SHALL be ignored in every other state.
REQ-005 In RUN, the block SHALL keep a 2-bit stage counter s and a 12-bit group counter j, both cleared on entry to RUN.
REQ-006 Issue: in a RUN cycle with hold=0, ROM_CEN SHALL be 0 and the address fields SHALL be derived as follows:
- e = (j << 4s) mod 4096.
- MA0 = e[3:0], MA1 = e[7:4], MA2 = e[11:8], each zero-extended to ADDR_W.
- After the issue, j SHALL increment; on j wrap 4095->0, s SHALL increment.
REQ-007 The issue of s=3, j=4095 SHALL move the state to DRAIN; no further addresses SHALL be issued.
REQ-008 With hold=1 in RUN:
- ROM_CEN SHALL be 1 and s and j SHALL be frozen.
- MA0/MA1/MA2 SHALL retain their last driven values.
- No issue SHALL occur.
REQ-009 ROM read latency is 1 cycle. tf_valid, tf_stage and tf_last SHALL be registered copies of the previous cycle's issue, its s, and (s==3 && j==4095).
REQ-010 DRAIN SHALL last exactly 1 cycle, then go to DONE.
REQ-011 DONE SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-012 Latency: with start at cycle t and no hold, the timing SHALL be:
- first issue at t+1;
- last issue at t+16384;
- tf_last at t+16385;
- done at t+16386;
- busy=0 at t+16387.
REQ-013 abort=1 in RUN or DRAIN SHALL force IDLE on the next edge. That same edge SHALL clear tf_valid, tf_last and tf_one, and no done pulse SHALL follow.
REQ-014 abort=1 in IDLE or DONE SHALL have no effect.
REQ-015 If abort and hold are both 1, abort SHALL win.
REQ-016 ROM_CEN SHALL be 1 in every state other than RUN.

Reset
REQ-017 rst=1 at a rising edge SHALL force the following, overriding start, abort and hold:
- state IDLE, s=0, j=0;
- ROM_CEN=1;
- MA0/MA1/MA2 = 0;
- tf_valid, tf_one, tf_last, done and busy = 0;
- tf_stage = 0.
REQ-018 Reset asserted mid-sweep SHALL discard the sweep; the first start after reset release SHALL begin again from s=0, j=0.

Configuration
REQ-019 Macro DTFAG_ZERO_SKIP_EN SHALL control unit-twiddle skipping.
- Defined: an issue with e==0 SHALL keep ROM_CEN=1 (no ROM access) while still counting as an issue. The following cycle SHALL assert tf_valid=1 and tf_one=1.
- Not defined: every issue SHALL drive ROM_CEN=0, and tf_one SHALL be constant 0.
- In both builds the port list and all other timing SHALL be identical.

Verification
REQ-020 Reset, then start, no hold -> 16384 tf_valid cycles; tf_last at t+16385; done at t+16386; busy low at t+16387.
REQ-021 Stage 1, j=0x123 -> e=0x230, so MA0=0, MA1=3, MA2=2. Stage 2, j=0x123 -> e=0x300, so MA0=0, MA1=0, MA2=3.
REQ-022 hold=1 for 5 cycles at s=0, j=10 -> ROM_CEN=1 and addresses frozen for 5 cycles, tf_valid low from the following cycle. Sweep completion is delayed by exactly 5 cycles.
REQ-023 abort at s=2, j=100 -> busy=0 next cycle; no done pulse; the next start restarts with MA fields derived from s=0, j=0.
REQ-024 With DTFAG_ZERO_SKIP_EN defined, a full sweep -> 4369 cycles with tf_one=1 (1+16+256+4096) and 12015 ROM_CEN=0 cycles. Without the macro -> 16384 ROM_CEN=0 cycles and tf_one never asserted.
REQ-025 rst=1 asserted at s=1, j=7 -> all outputs at their reset values next cycle; start in that same rst cycle is ignored.
